// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/funct/ALU encodings and the control bundle carried down the
// pipeline by pipe_controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam int ALU_W = 3;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
    logic             branch;
    logic             branchne;
    logic             alusrc;
    logic             regdst;
    logic [ALU_W-1:0] alu;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/main_decoder.sv
// Combinational decode-stage control decoder; anything unrecognised becomes a
// bubble and raises illegal.
module main_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int EN_BNE  = 1,
  parameter int EN_JUMP = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       jump,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    jump    = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu = ALU_ADD;
          FN_SUB:  ctrl.alu = ALU_SUB;
          FN_AND:  ctrl.alu = ALU_AND;
          FN_OR:   ctrl.alu = ALU_OR;
          FN_SLT:  ctrl.alu = ALU_SLT;
          default: begin
            ctrl    = CTRL_BUBBLE;
            illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.alu      = ALU_ADD;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.alu      = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu    = ALU_SUB;
      end
      OP_BNE: begin
        if (EN_BNE != 0) begin
          ctrl.branch   = 1'b1;
          ctrl.branchne = 1'b1;
          ctrl.alu      = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.alu      = ALU_ADD;
      end
      // A jump resolves in decode, so nothing follows it down the pipe.
      OP_J: begin
        if (EN_JUMP != 0) jump = 1'b1;
        else              illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined MIPS control path: D->E->M->WB control registers with stall
// bubbles, taken-branch squash of E and M, and a saturating bubble counter.
module pipe_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int EN_BNE    = 1,
  parameter int EN_JUMP   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 STALL,
  input  logic                 ZERO_M,
  output logic                 JUMP_D,
  output logic                 ILLEGAL_D,
  output logic                 REGWRITE_E,
  output logic                 MEMTOREG_E,
  output logic                 MEMWRITE_E,
  output logic                 BRANCH_E,
  output logic                 ALUSRC_E,
  output logic                 REGDST_E,
  output logic [ALUCTRL_W-1:0] ALUCONTROL_E,
  output logic                 REGWRITE_M,
  output logic                 MEMTOREG_M,
  output logic                 MEMWRITE_M,
  output logic                 BRANCH_M,
  output logic                 PCSRC_M,
  output logic                 REGWRITE_WB,
  output logic                 MEMTOREG_WB,
  output logic [CNT_W-1:0]     BUBBLE_CNT
);

  ctrl_t            ctrl_d;
  ctrl_t            ctrl_e;
  logic             regwrite_m, memtoreg_m, memwrite_m, branch_m, branchne_m;
  logic             regwrite_wb, memtoreg_wb;
  logic [CNT_W-1:0] bubble_cnt;
  logic             squash;
  logic             bubble_e;

  main_decoder #(.EN_BNE(EN_BNE), .EN_JUMP(EN_JUMP)) u_main_decoder (
    .opcode  (opcode),
    .funct   (funct),
    .ctrl    (ctrl_d),
    .jump    (JUMP_D),
    .illegal (ILLEGAL_D)
  );

  // bne reuses the beq datapath; branchne just inverts the zero sense.
  assign squash   = branch_m & (ZERO_M ^ branchne_m);
  assign bubble_e = STALL | squash;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctrl_e      <= CTRL_BUBBLE;
      regwrite_m  <= 1'b0;
      memtoreg_m  <= 1'b0;
      memwrite_m  <= 1'b0;
      branch_m    <= 1'b0;
      branchne_m  <= 1'b0;
      regwrite_wb <= 1'b0;
      memtoreg_wb <= 1'b0;
      bubble_cnt  <= '0;
    end else begin
      ctrl_e <= bubble_e ? CTRL_BUBBLE : ctrl_d;
      if (squash) begin
        regwrite_m <= 1'b0;
        memtoreg_m <= 1'b0;
        memwrite_m <= 1'b0;
        branch_m   <= 1'b0;
        branchne_m <= 1'b0;
      end else begin
        regwrite_m <= ctrl_e.regwrite;
        memtoreg_m <= ctrl_e.memtoreg;
        memwrite_m <= ctrl_e.memwrite;
        branch_m   <= ctrl_e.branch;
        branchne_m <= ctrl_e.branchne;
      end
      regwrite_wb <= regwrite_m;
      memtoreg_wb <= memtoreg_m;
      if (bubble_e && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign REGWRITE_E   = ctrl_e.regwrite;
  assign MEMTOREG_E   = ctrl_e.memtoreg;
  assign MEMWRITE_E   = ctrl_e.memwrite;
  assign BRANCH_E     = ctrl_e.branch;
  assign ALUSRC_E     = ctrl_e.alusrc;
  assign REGDST_E     = ctrl_e.regdst;
  assign ALUCONTROL_E = ALUCTRL_W'(ctrl_e.alu);
  assign REGWRITE_M   = regwrite_m;
  assign MEMTOREG_M   = memtoreg_m;
  assign MEMWRITE_M   = memwrite_m;
  assign BRANCH_M     = branch_m;
  assign PCSRC_M      = squash;
  assign REGWRITE_WB  = regwrite_wb;
  assign MEMTOREG_WB  = memtoreg_wb;
  assign BUBBLE_CNT   = bubble_cnt;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: default build, a build without bne,
// and a build with a wide ALU field and a 2-bit bubble counter.
module tb_pipe_controller;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_BNE   = 6'b000101;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BAD   = 6'b111111;

  // E bundle = {regwrite, memtoreg, memwrite, branch, alusrc, regdst, alu[2:0]}
  localparam logic [8:0] E_LW   = 9'b110010010;
  localparam logic [8:0] E_ADD  = 9'b100001010;
  localparam logic [8:0] E_SUB  = 9'b100001110;
  localparam logic [8:0] E_AND  = 9'b100001000;
  localparam logic [8:0] E_OR   = 9'b100001001;
  localparam logic [8:0] E_SLT  = 9'b100001111;
  localparam logic [8:0] E_SW   = 9'b001010010;
  localparam logic [8:0] E_ADDI = 9'b100010010;
  localparam logic [8:0] E_BR   = 9'b000100110;

  localparam int S_E = 0, S_M = 1, S_WB = 2, S_PC = 3, S_CNT = 4, S_ILL = 5, S_JMP = 6;
  localparam int S_NB_ILL = 7, S_NB_PC = 8, S_C2_CNT = 9, S_C2_ALU = 10, S_NB_ALL = 11, S_C2_ALL = 12;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [5:0] opcode = T_ADDI;
  logic [5:0] funct = 6'b0;
  logic STALL = 1'b0;
  logic ZERO_M = 1'b0;

  logic jump_d, illegal_d, rw_e, mtr_e, mw_e, br_e, as_e, rd_e;
  logic [2:0] alu_e;
  logic rw_m, mtr_m, mw_m, br_m, pcsrc_m, rw_wb, mtr_wb;
  logic [15:0] cnt;

  logic nb_jump, nb_ill, nb_rw_e, nb_mtr_e, nb_mw_e, nb_br_e, nb_as_e, nb_rd_e;
  logic [2:0] nb_alu_e;
  logic nb_rw_m, nb_mtr_m, nb_mw_m, nb_br_m, nb_pc, nb_rw_wb, nb_mtr_wb;
  logic [15:0] nb_cnt;

  logic c2_jump, c2_ill, c2_rw_e, c2_mtr_e, c2_mw_e, c2_br_e, c2_as_e, c2_rd_e;
  logic [4:0] c2_alu_e;
  logic c2_rw_m, c2_mtr_m, c2_mw_m, c2_br_m, c2_pc, c2_rw_wb, c2_mtr_wb;
  logic [1:0] c2_cnt;

  logic [8:0]  e_vec;
  logic [3:0]  m_vec;
  logic [1:0]  wb_vec;
  logic [33:0] nb_all;
  logic [21:0] c2_all;

  assign e_vec  = {rw_e, mtr_e, mw_e, br_e, as_e, rd_e, alu_e};
  assign m_vec  = {rw_m, mtr_m, mw_m, br_m};
  assign wb_vec = {rw_wb, mtr_wb};
  assign nb_all = {nb_rw_e, nb_mtr_e, nb_mw_e, nb_br_e, nb_as_e, nb_rd_e, nb_alu_e,
                   nb_rw_m, nb_mtr_m, nb_mw_m, nb_br_m, nb_pc, nb_rw_wb, nb_mtr_wb,
                   nb_cnt, nb_jump, nb_ill};
  assign c2_all = {c2_rw_e, c2_mtr_e, c2_mw_e, c2_br_e, c2_as_e, c2_rd_e, c2_alu_e,
                   c2_rw_m, c2_mtr_m, c2_mw_m, c2_br_m, c2_pc, c2_rw_wb, c2_mtr_wb,
                   c2_cnt, c2_jump, c2_ill};

  pipe_controller dut (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .funct(funct), .STALL(STALL), .ZERO_M(ZERO_M),
    .JUMP_D(jump_d), .ILLEGAL_D(illegal_d),
    .REGWRITE_E(rw_e), .MEMTOREG_E(mtr_e), .MEMWRITE_E(mw_e), .BRANCH_E(br_e),
    .ALUSRC_E(as_e), .REGDST_E(rd_e), .ALUCONTROL_E(alu_e),
    .REGWRITE_M(rw_m), .MEMTOREG_M(mtr_m), .MEMWRITE_M(mw_m), .BRANCH_M(br_m),
    .PCSRC_M(pcsrc_m), .REGWRITE_WB(rw_wb), .MEMTOREG_WB(mtr_wb), .BUBBLE_CNT(cnt)
  );

  pipe_controller #(.EN_BNE(0)) dut_nb (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .funct(funct), .STALL(STALL), .ZERO_M(ZERO_M),
    .JUMP_D(nb_jump), .ILLEGAL_D(nb_ill),
    .REGWRITE_E(nb_rw_e), .MEMTOREG_E(nb_mtr_e), .MEMWRITE_E(nb_mw_e), .BRANCH_E(nb_br_e),
    .ALUSRC_E(nb_as_e), .REGDST_E(nb_rd_e), .ALUCONTROL_E(nb_alu_e),
    .REGWRITE_M(nb_rw_m), .MEMTOREG_M(nb_mtr_m), .MEMWRITE_M(nb_mw_m), .BRANCH_M(nb_br_m),
    .PCSRC_M(nb_pc), .REGWRITE_WB(nb_rw_wb), .MEMTOREG_WB(nb_mtr_wb), .BUBBLE_CNT(nb_cnt)
  );

  pipe_controller #(.ALUCTRL_W(5), .CNT_W(2)) dut_c2 (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .funct(funct), .STALL(STALL), .ZERO_M(ZERO_M),
    .JUMP_D(c2_jump), .ILLEGAL_D(c2_ill),
    .REGWRITE_E(c2_rw_e), .MEMTOREG_E(c2_mtr_e), .MEMWRITE_E(c2_mw_e), .BRANCH_E(c2_br_e),
    .ALUSRC_E(c2_as_e), .REGDST_E(c2_rd_e), .ALUCONTROL_E(c2_alu_e),
    .REGWRITE_M(c2_rw_m), .MEMTOREG_M(c2_mtr_m), .MEMWRITE_M(c2_mw_m), .BRANCH_M(c2_br_m),
    .PCSRC_M(c2_pc), .REGWRITE_WB(c2_rw_wb), .MEMTOREG_WB(c2_mtr_wb), .BUBBLE_CNT(c2_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       stall;
    logic       zero;
  } row_t;

  exp_t q[$];
  row_t rows[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_E:      return 64'(e_vec);
      S_M:      return 64'(m_vec);
      S_WB:     return 64'(wb_vec);
      S_PC:     return 64'(pcsrc_m);
      S_CNT:    return 64'(cnt);
      S_ILL:    return 64'(illegal_d);
      S_JMP:    return 64'(jump_d);
      S_NB_ILL: return 64'(nb_ill);
      S_NB_PC:  return 64'(nb_pc);
      S_C2_CNT: return 64'(c2_cnt);
      S_C2_ALU: return 64'(c2_alu_e);
      S_NB_ALL: return 64'(nb_all);
      S_C2_ALL: return 64'(c2_all);
      default:  return '1;
    endcase
  endfunction

  task automatic add_row(input logic [5:0] op, input logic [5:0] fn, input logic st, input logic z);
    rows.push_back('{op, fn, st, z});
  endtask

  task automatic expect_at(input int due, input int sel, input logic [63:0] val, input string name);
    q.push_back('{due, sel, val, name});
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #2;
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    #1 RESET = 1'b0;
    #1;
    n_tests++; if (e_vec !== 9'b0) begin n_fail++; $display("FAIL reset_e: got %0h expected 0", e_vec); end
    n_tests++; if ({m_vec, wb_vec, pcsrc_m} !== 7'b0) begin n_fail++; $display("FAIL reset_m_wb: got %0h expected 0", {m_vec, wb_vec, pcsrc_m}); end
    n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    n_tests++; if (nb_all !== 34'b0) begin n_fail++; $display("FAIL reset_nb_all: got %0h expected 0", nb_all); end
    n_tests++; if (c2_all !== 22'b0) begin n_fail++; $display("FAIL reset_c2_all: got %0h expected 0", c2_all); end
    @(posedge CLK); #1;
    n_tests++; if (e_vec !== 9'b0) begin n_fail++; $display("FAIL reset_hold_e: got %0h expected 0", e_vec); end
    RESET = 1'b1;
  endtask

  task automatic test_lw_pipeline();
    do_reset();
    add_row(T_LW, 6'b0, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b0, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b0, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b0, 1'b0, 1'b0);
    expect_at(0, S_ILL, 64'd0, "lw_legal");
    expect_at(1, S_E, 64'(E_LW), "lw_e");
    expect_at(1, S_ILL, 64'd1, "nop_illegal");
    expect_at(2, S_M, 64'(4'b1100), "lw_m");
    expect_at(2, S_E, 64'd0, "nop_e");
    expect_at(2, S_WB, 64'd0, "lw_wb_early");
    expect_at(3, S_WB, 64'(2'b11), "lw_wb");
    expect_at(3, S_M, 64'd0, "nop_m");
    expect_at(3, S_CNT, 64'd0, "lw_cnt");
    for (int c = 0; c < rows.size(); c++) begin
      opcode = rows[c].op; funct = rows[c].fn; STALL = rows[c].stall; ZERO_M = rows[c].zero;
      #1;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == c) begin
          n_tests++;
          if (observe(q[i].sel) !== q[i].val) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", q[i].name, observe(q[i].sel), q[i].val);
          end
          q.delete(i);
        end
      end
      @(posedge CLK); #1;
    end
    n_tests++;
    if (q.size() != 0) begin n_fail++; $display("FAIL lw_leftover: got %0d pending expected 0", q.size()); q.delete(); end
    rows.delete();
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_row(T_RTYPE, 6'b100000, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b100010, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b100100, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b100101, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b101010, 1'b0, 1'b0);
    add_row(T_SW, 6'b0, 1'b0, 1'b0);
    add_row(T_ADDI, 6'b0, 1'b0, 1'b0);
    add_row(T_J, 6'b0, 1'b0, 1'b0);
    add_row(T_BAD, 6'b0, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b000001, 1'b0, 1'b0);
    add_row(T_ADDI, 6'b0, 1'b0, 1'b0);
    expect_at(1, S_E, 64'(E_ADD), "add_e");
    expect_at(2, S_E, 64'(E_SUB), "sub_e");
    expect_at(2, S_C2_ALU, 64'(5'b00110), "sub_alu_w5");
    expect_at(3, S_E, 64'(E_AND), "and_e");
    expect_at(4, S_E, 64'(E_OR), "or_e");
    expect_at(5, S_E, 64'(E_SLT), "slt_e");
    expect_at(5, S_C2_ALU, 64'(5'b00111), "slt_alu_w5");
    expect_at(6, S_E, 64'(E_SW), "sw_e");
    expect_at(7, S_E, 64'(E_ADDI), "addi_e");
    expect_at(7, S_M, 64'(4'b0010), "sw_m");
    expect_at(7, S_JMP, 64'd1, "j_jump");
    expect_at(7, S_ILL, 64'd0, "j_legal");
    expect_at(8, S_E, 64'd0, "j_e");
    expect_at(8, S_ILL, 64'd1, "badop_illegal");
    expect_at(8, S_JMP, 64'd0, "badop_nojump");
    expect_at(9, S_E, 64'd0, "badop_e");
    expect_at(9, S_WB, 64'(2'b10), "addi_wb");
    expect_at(9, S_ILL, 64'd1, "badfn_illegal");
    expect_at(10, S_E, 64'd0, "badfn_e");
    expect_at(10, S_CNT, 64'd0, "illegal_not_counted");
    for (int c = 0; c < rows.size(); c++) begin
      opcode = rows[c].op; funct = rows[c].fn; STALL = rows[c].stall; ZERO_M = rows[c].zero;
      #1;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == c) begin
          n_tests++;
          if (observe(q[i].sel) !== q[i].val) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", q[i].name, observe(q[i].sel), q[i].val);
          end
          q.delete(i);
        end
      end
      @(posedge CLK); #1;
    end
    n_tests++;
    if (q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d pending expected 0", q.size()); q.delete(); end
    rows.delete();
  endtask

  task automatic test_branch();
    do_reset();
    add_row(T_BEQ, 6'b0, 1'b0, 1'b0);
    add_row(T_ADDI, 6'b0, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b100000, 1'b1, 1'b1);
    add_row(T_BEQ, 6'b0, 1'b0, 1'b0);
    add_row(T_ADDI, 6'b0, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b100000, 1'b0, 1'b0);
    add_row(T_BNE, 6'b0, 1'b0, 1'b0);
    add_row(T_ADDI, 6'b0, 1'b0, 1'b0);
    add_row(T_RTYPE, 6'b100000, 1'b0, 1'b0);
    add_row(T_ADDI, 6'b0, 1'b0, 1'b0);
    add_row(T_ADDI, 6'b0, 1'b0, 1'b0);
    expect_at(1, S_E, 64'(E_BR), "beq_e");
    expect_at(2, S_M, 64'(4'b0001), "beq_m");
    expect_at(2, S_PC, 64'd1, "beq_taken_pcsrc");
    expect_at(2, S_NB_PC, 64'd1, "beq_taken_nobne_build");
    expect_at(3, S_E, 64'd0, "squash_e");
    expect_at(3, S_M, 64'd0, "squash_m");
    expect_at(3, S_CNT, 64'd1, "squash_stall_cnt");
    expect_at(3, S_PC, 64'd0, "after_squash_pcsrc");
    expect_at(4, S_E, 64'(E_BR), "beq2_e");
    expect_at(5, S_PC, 64'd0, "beq_not_taken");
    expect_at(6, S_E, 64'(E_ADD), "no_squash_e");
    expect_at(6, S_M, 64'(4'b1000), "no_squash_m");
    expect_at(6, S_CNT, 64'd1, "no_squash_cnt");
    expect_at(6, S_ILL, 64'd0, "bne_legal");
    expect_at(6, S_NB_ILL, 64'd1, "bne_illegal_nobne");
    expect_at(7, S_E, 64'(E_BR), "bne_e");
    expect_at(8, S_PC, 64'd1, "bne_taken_pcsrc");
    expect_at(8, S_NB_PC, 64'd0, "bne_nobne_no_branch");
    expect_at(9, S_E, 64'd0, "bne_squash_e");
    expect_at(9, S_M, 64'd0, "bne_squash_m");
    expect_at(9, S_CNT, 64'd2, "bne_squash_cnt");
    expect_at(10, S_E, 64'(E_ADDI), "post_squash_resume");
    for (int c = 0; c < rows.size(); c++) begin
      opcode = rows[c].op; funct = rows[c].fn; STALL = rows[c].stall; ZERO_M = rows[c].zero;
      #1;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == c) begin
          n_tests++;
          if (observe(q[i].sel) !== q[i].val) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", q[i].name, observe(q[i].sel), q[i].val);
          end
          q.delete(i);
        end
      end
      @(posedge CLK); #1;
    end
    n_tests++;
    if (q.size() != 0) begin n_fail++; $display("FAIL branch_leftover: got %0d pending expected 0", q.size()); q.delete(); end
    rows.delete();
  endtask

  task automatic test_stall_saturate();
    do_reset();
    for (int k = 0; k < 5; k++) add_row(T_RTYPE, 6'b100000, 1'b1, 1'b0);
    add_row(T_RTYPE, 6'b100000, 1'b0, 1'b0);
    add_row(T_ADDI, 6'b0, 1'b0, 1'b0);
    expect_at(1, S_E, 64'd0, "stall_e1");
    expect_at(1, S_C2_CNT, 64'd1, "cnt2_1");
    expect_at(2, S_E, 64'd0, "stall_e2");
    expect_at(2, S_C2_CNT, 64'd2, "cnt2_2");
    expect_at(3, S_E, 64'd0, "stall_e3");
    expect_at(3, S_CNT, 64'd3, "stall_cnt3");
    expect_at(3, S_C2_CNT, 64'd3, "cnt2_3");
    expect_at(4, S_C2_CNT, 64'd3, "cnt2_sat4");
    expect_at(5, S_CNT, 64'd5, "stall_cnt5");
    expect_at(5, S_C2_CNT, 64'd3, "cnt2_sat5");
    expect_at(6, S_E, 64'(E_ADD), "add_after_stall");
    expect_at(6, S_C2_ALU, 64'(5'b00010), "add_alu_w5");
    expect_at(6, S_CNT, 64'd5, "cnt_hold");
    for (int c = 0; c < rows.size(); c++) begin
      opcode = rows[c].op; funct = rows[c].fn; STALL = rows[c].stall; ZERO_M = rows[c].zero;
      #1;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == c) begin
          n_tests++;
          if (observe(q[i].sel) !== q[i].val) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", q[i].name, observe(q[i].sel), q[i].val);
          end
          q.delete(i);
        end
      end
      @(posedge CLK); #1;
    end
    n_tests++;
    if (q.size() != 0) begin n_fail++; $display("FAIL stall_leftover: got %0d pending expected 0", q.size()); q.delete(); end
    rows.delete();
  endtask

  task automatic test_reset_mid_branch();
    do_reset();
    opcode = T_BEQ; funct = 6'b0; STALL = 1'b0; ZERO_M = 1'b1;
    @(posedge CLK); #1;
    opcode = T_ADDI;
    @(posedge CLK); #1;
    n_tests++; if (pcsrc_m !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_pcsrc: got %b expected 1", pcsrc_m); end
    RESET = 1'b0;
    #1;
    n_tests++; if (pcsrc_m !== 1'b0) begin n_fail++; $display("FAIL midrst_pcsrc: got %b expected 0", pcsrc_m); end
    n_tests++; if ({e_vec, m_vec, wb_vec} !== 15'b0) begin n_fail++; $display("FAIL midrst_regs: got %0h expected 0", {e_vec, m_vec, wb_vec}); end
    n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected 0", cnt); end
    #1 RESET = 1'b1;
    opcode = T_RTYPE; funct = 6'b100000; ZERO_M = 1'b0;
    @(posedge CLK); #1;
    n_tests++; if (e_vec !== E_ADD) begin n_fail++; $display("FAIL midrst_resume_e: got %0h expected %0h", e_vec, E_ADD); end
    n_tests++; if (m_vec !== 4'b0) begin n_fail++; $display("FAIL midrst_resume_m: got %0h expected 0", m_vec); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw_pipeline();
    test_back_to_back();
    test_branch();
    test_stall_saturate();
    test_reset_mid_branch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
